dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_if.sv | 23 ++
 rtl/dmem_responder.sv | 94 +++++++++
 tb/tb_dmem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Request/response bus between a memory initiator and dmem_responder.
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_responder.sv
// Single-port word memory answering one request at a time after a fixed latency,
// with byte-enabled writes and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst,
    dmem_responder_if.slave    bus,
    output logic               busy
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic                latWe;
    logic                latErr;
    logic [ADDR_W-1:0]   latIdx;
    logic [31:0]         latWdata;
    logic [3:0]          latBe;
    logic [31:0]         mem [DEPTH];

    logic                reqErr_c;
    logic                commit_c;

    // Misaligned, or any address bit above the word index set
    assign reqErr_c = (bus.req_addr[1:0] != 2'b00) ||
                      ((bus.req_addr >> (ADDR_W + 2)) != 32'd0);
    assign commit_c = (state == WAIT) && (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            latWe          <= 1'b0;
            latErr         <= 1'b0;
            latIdx         <= '0;
            latWdata       <= '0;
            latBe          <= '0;
            busy           <= 1'b0;
            bus.req_ready  <= 1'b1;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        latWe         <= bus.req_we;
                        latErr        <= reqErr_c;
                        latIdx        <= bus.req_addr[ADDR_W+1:2];
                        latWdata      <= bus.req_wdata;
                        latBe         <= bus.req_be;
                        cnt           <= CNT_W'(LATENCY - 1);
                        state         <= WAIT;
                        busy          <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= latErr;
                        bus.resp_rdata <= (latErr || latWe) ? 32'd0 : mem[latIdx];
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state          <= IDLE;
                        busy           <= 1'b0;
                        bus.req_ready  <= 1'b1;
                        bus.resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Storage is never reset; reset forces IDLE asynchronously, which blocks any pending commit
    always_ff @(posedge clk) begin
        if (commit_c && latWe && !latErr) begin
            for (int i = 0; i < 4; i++) begin
                if (latBe[i]) mem[latIdx][8*i +: 8] <= latWdata[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Randomized self-checking bench for dmem_responder against an array-based memory model.
module tb_dmem_responder;
    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned LATENCY = 2;
    localparam int unsigned DEPTH   = 1 << ADDR_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;
    logic busy2;

    dmem_responder_if bus ();
    dmem_responder_if bus2 ();

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk (clk), .rst (rst), .bus (bus), .busy (busy)
    );
    dmem_responder #(.ADDR_W(4), .LATENCY(1)) dut2 (
        .clk (clk), .rst (rst), .bus (bus2), .busy (busy2)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] refMem [DEPTH];

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference: an access either errors, merges enabled bytes into the word, or returns it
    function automatic void modelAccess(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata, input logic [3:0] be,
                                        output logic [31:0] rdata, output logic err);
        logic [31:0] mask;
        int idx;
        err   = (addr % 4 != 0) || (addr >= 32'(4 * DEPTH));
        rdata = 32'd0;
        if (!err) begin
            idx = int'(addr / 4);
            if (we) begin
                mask = {be[3] ? 8'hFF : 8'h00, be[2] ? 8'hFF : 8'h00,
                        be[1] ? 8'hFF : 8'h00, be[0] ? 8'hFF : 8'h00};
                refMem[idx] = (refMem[idx] & ~mask) | (wdata & mask);
            end else begin
                rdata = refMem[idx];
            end
        end
    endfunction

    task automatic scrambleReq();
        bus.req_we    = 1'($urandom);
        bus.req_addr  = $urandom;
        bus.req_wdata = $urandom;
        bus.req_be    = 4'($urandom);
    endtask

    task automatic doTxn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input int hold);
        logic [31:0] expData;
        logic        expErr;
        int          n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        checkEq("req_ready_idle", 32'(bus.req_ready), 32'd1);
        modelAccess(we, addr, wdata, be, expData, expErr);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        scrambleReq();
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!bus.resp_valid && n < 40);
        checkEq("latency", 32'(n), 32'(LATENCY));
        checkEq("rdata", bus.resp_rdata, expData);
        checkEq("err", 32'(bus.resp_err), 32'(expErr));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            checkEq("hold_valid", 32'(bus.resp_valid), 32'd1);
            checkEq("hold_rdata", bus.resp_rdata, expData);
            checkEq("hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        // A request raised on the completion edge must not be taken
        bus.resp_ready = 1'b1;
        bus.req_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b0;
        checkEq("done_valid", 32'(bus.resp_valid), 32'd0);
        checkEq("done_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("done_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int stamps[$];
        logic [31:0] addr;
        int sel;

        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        scrambleReq();
        bus2.req_valid  = 1'b0;
        bus2.req_we     = 1'b1;
        bus2.req_addr   = 32'd0;
        bus2.req_wdata  = 32'h0;
        bus2.req_be     = 4'hF;
        bus2.resp_ready = 1'b1;

        #7;
        checkEq("rst_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        checkEq("rst_rdata", bus.resp_rdata, 32'd0);
        checkEq("rst_err", 32'(bus.resp_err), 32'd0);
        checkEq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LATENCY=1 streaming: one completion every 3 cycles
        bus2.req_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            bus2.req_wdata = $urandom;
            if (bus2.resp_valid) stamps.push_back(c);
        end
        bus2.req_valid = 1'b0;
        checkEq("l1_count_ok", 32'(stamps.size() >= 12), 32'd1);
        for (int i = 1; i < stamps.size(); i++)
            checkEq("l1_period", 32'(stamps[i] - stamps[i-1]), 32'd3);

        for (int w = 0; w < int'(DEPTH); w++)
            doTxn(1'b1, 32'(w * 4), $urandom, 4'hF, 0);

        doTxn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
        doTxn(1'b0, 32'h10, 32'h0, 4'h0, 0);
        checkEq("raw_const", refMem[4], 32'hDEADBEEF);
        doTxn(1'b1, 32'h14, 32'h11223344, 4'hF, 0);
        doTxn(1'b1, 32'h14, 32'hAABBCCDD, 4'h5, 0);
        doTxn(1'b0, 32'h14, 32'h0, 4'h0, 1);
        checkEq("be_const", refMem[5], 32'h11BB33DD);
        doTxn(1'b0, 32'h12, 32'h0, 4'h0, 0);
        doTxn(1'b1, 32'h400, 32'h55555555, 4'hF, 0);
        doTxn(1'b0, 32'h0, 32'h0, 4'h0, 0);
        doTxn(1'b0, 32'h10, 32'h0, 4'h0, 5);

        // Reset in WAIT abandons the write
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hCAFEF00D;
        bus.req_be    = 4'hF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        checkEq("mid_busy", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        checkEq("arst_busy", 32'(busy), 32'd0);
        checkEq("arst_req_ready", 32'(bus.req_ready), 32'd1);
        checkEq("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkEq("post_rst_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        doTxn(1'b0, 32'h20, 32'h0, 4'h0, 0);

        for (int t = 0; t < 150; t++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)
                addr = {22'd0, 8'($urandom), 2'($urandom_range(1, 3))};
            else if (sel == 1)
                addr = (32'($urandom_range(1, 1000)) << 10) | 32'($urandom_range(0, 1023));
            else
                addr = {22'd0, 8'($urandom), 2'b00};
            doTxn(1'($urandom), addr, $urandom, 4'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end
endmodule
